draw_fifo_axi_master: RTL and testbench

AXI4-Lite master that feeds triangle commands into the draw FIFO peripheral. It accepts one triangle per valid/ready handshake on a local command port and checks FIFO space by reading REG_STATUS. It then issues four 32-bit writes to REG_FIFO. After reset it performs the engine wake-up write. It sits between a vertex/transform stage and the draw FIFO's AXI4-Lite slave port.

---
 rtl/draw_fifo_pkg.sv | 32 +++
 rtl/draw_fifo_axi_master_if.sv | 48 ++++
 rtl/draw_fifo_axi_master_axil_single_write.sv | 73 +++++++
 rtl/draw_fifo_axi_master.sv | 185 ++++++++++++++++++
 tb/tb_draw_fifo_axi_master.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/draw_fifo_pkg.sv
// rtl/draw_fifo_pkg.sv - register map, command constants and FSM state type for the draw FIFO master
package draw_fifo_pkg;

    localparam logic [31:0] REG_FIFO         = 32'h0000_0000;
    localparam logic [31:0] REG_STATUS       = 32'h0000_0004;
    localparam logic [31:0] WAKE_CMD         = 32'h8000_0000;
    localparam int          STATUS_FULL_BIT  = 0;
    localparam logic [1:0]  AXI_RESP_OKAY    = 2'b00;
    localparam logic [2:0]  AXI_PROT_DEFAULT = 3'b000;
    localparam logic [3:0]  AXI_STRB_FULL    = 4'hF;

    typedef enum logic [2:0] {
        ST_WAKE_AW,
        ST_WAKE_B,
        ST_IDLE,
        ST_POLL_AR,
        ST_POLL_R,
        ST_WR_AW,
        ST_WR_B
    } state_e;

    // Element 0 is the first word written to the FIFO; each word carries its low-half field in [15:0].
    function automatic logic [3:0][31:0] pack_triangle(
        input logic [15:0] x1, input logic [15:0] y1,
        input logic [15:0] x2, input logic [15:0] y2,
        input logic [15:0] x3, input logic [15:0] c1,
        input logic [15:0] c2, input logic [15:0] c3
    );
        pack_triangle = {c3, c2, c1, x3, y2, x2, y1, x1};
    endfunction

endpackage

// File: rtl/draw_fifo_axi_master_if.sv
// rtl/draw_fifo_axi_master_if.sv - AXI4-Lite bus bundle between the draw FIFO master and its slave
interface draw_fifo_axi_master_if #(
    parameter int ADDR_W = 32
);
    logic [ADDR_W-1:0] m00_axi_awaddr;
    logic [2:0]        m00_axi_awprot;
    logic              m00_axi_awvalid;
    logic              m00_axi_awready;
    logic [31:0]       m00_axi_wdata;
    logic [3:0]        m00_axi_wstrb;
    logic              m00_axi_wvalid;
    logic              m00_axi_wready;
    logic [1:0]        m00_axi_bresp;
    logic              m00_axi_bvalid;
    logic              m00_axi_bready;
    logic [ADDR_W-1:0] m00_axi_araddr;
    logic [2:0]        m00_axi_arprot;
    logic              m00_axi_arvalid;
    logic              m00_axi_arready;
    logic [31:0]       m00_axi_rdata;
    logic [1:0]        m00_axi_rresp;
    logic              m00_axi_rvalid;
    logic              m00_axi_rready;

    modport master (
        output m00_axi_awaddr, m00_axi_awprot, m00_axi_awvalid,
        output m00_axi_wdata, m00_axi_wstrb, m00_axi_wvalid,
        output m00_axi_bready,
        output m00_axi_araddr, m00_axi_arprot, m00_axi_arvalid,
        output m00_axi_rready,
        input  m00_axi_awready, m00_axi_wready,
        input  m00_axi_bresp, m00_axi_bvalid,
        input  m00_axi_arready,
        input  m00_axi_rdata, m00_axi_rresp, m00_axi_rvalid
    );

    modport slave (
        input  m00_axi_awaddr, m00_axi_awprot, m00_axi_awvalid,
        input  m00_axi_wdata, m00_axi_wstrb, m00_axi_wvalid,
        input  m00_axi_bready,
        input  m00_axi_araddr, m00_axi_arprot, m00_axi_arvalid,
        input  m00_axi_rready,
        output m00_axi_awready, m00_axi_wready,
        output m00_axi_bresp, m00_axi_bvalid,
        output m00_axi_arready,
        output m00_axi_rdata, m00_axi_rresp, m00_axi_rvalid
    );
endinterface

// File: rtl/draw_fifo_axi_master_axil_single_write.sv
// rtl/draw_fifo_axi_master_axil_single_write.sv - one AXI4-Lite write: AW and W retire independently, then B
module axil_single_write
    import draw_fifo_pkg::*;
#(
    parameter int AW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start_i,
    input  logic [AW-1:0] addr_i,
    input  logic [31:0]   data_i,
    output logic [AW-1:0] awaddr_o,
    output logic          awvalid_o,
    input  logic          awready_i,
    output logic [31:0]   wdata_o,
    output logic          wvalid_o,
    input  logic          wready_i,
    input  logic [1:0]    bresp_i,
    input  logic          bvalid_i,
    output logic          bready_o,
    output logic          idle_o,
    output logic          req_done_o,
    output logic          resp_done_o,
    output logic          resp_err_o
);

    logic [AW-1:0] awaddr_q;
    logic [31:0]   wdata_q;
    logic          awvalid_q;
    logic          wvalid_q;
    logic          bready_q;
    logic          aw_take;
    logic          w_take;

    always_comb begin
        aw_take     = awvalid_q & awready_i;
        w_take      = wvalid_q & wready_i;
        // The request phase is over once every channel still pending is taken this cycle.
        req_done_o  = (awvalid_q | wvalid_q) & (~awvalid_q | awready_i) & (~wvalid_q | wready_i);
        resp_done_o = bready_q & bvalid_i;
        resp_err_o  = resp_done_o & (bresp_i != AXI_RESP_OKAY);
        idle_o      = ~(awvalid_q | wvalid_q | bready_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            awaddr_q  <= '0;
            wdata_q   <= '0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
        end else begin
            if (aw_take)     awvalid_q <= 1'b0;
            if (w_take)      wvalid_q  <= 1'b0;
            if (req_done_o)  bready_q  <= 1'b1;
            if (resp_done_o) bready_q  <= 1'b0;
            // A new start may coincide with the previous B handshake so back-to-back words lose no cycle.
            if (start_i) begin
                awaddr_q  <= addr_i;
                wdata_q   <= data_i;
                awvalid_q <= 1'b1;
                wvalid_q  <= 1'b1;
            end
        end
    end

    assign awaddr_o  = awaddr_q;
    assign awvalid_o = awvalid_q;
    assign wdata_o   = wdata_q;
    assign wvalid_o  = wvalid_q;
    assign bready_o  = bready_q;

endmodule

// File: rtl/draw_fifo_axi_master.sv
// rtl/draw_fifo_axi_master.sv - feeds triangle commands into the draw FIFO over AXI4-Lite after polling its status
module draw_fifo_axi_master
    import draw_fifo_pkg::*;
#(
    parameter int          C_M00_AXI_ADDR_WIDTH = 32,
    parameter logic [31:0] C_BASE_ADDR          = 32'h0
) (
    input  logic        m00_axi_aclk,
    input  logic        m00_axi_areset,
    input  logic        tri_valid,
    output logic        tri_ready,
    input  logic [15:0] tri_x1,
    input  logic [15:0] tri_y1,
    input  logic [15:0] tri_x2,
    input  logic [15:0] tri_y2,
    input  logic [15:0] tri_x3,
    input  logic [15:0] tri_c1,
    input  logic [15:0] tri_c2,
    input  logic [15:0] tri_c3,
    output logic        busy,
    output logic        err,
    output logic [15:0] tri_count,
    draw_fifo_axi_master_if.master m00_axi
);

    localparam int AW = C_M00_AXI_ADDR_WIDTH;
    localparam logic [AW-1:0] FIFO_ADDR   = AW'(C_BASE_ADDR + REG_FIFO);
    localparam logic [AW-1:0] STATUS_ADDR = AW'(C_BASE_ADDR + REG_STATUS);

    state_e          state_q;
    logic [3:0][31:0] word_q;
    logic [1:0]      idx_q;
    logic [AW-1:0]   araddr_q;
    logic            arvalid_q;
    logic            rready_q;
    logic            tri_ready_q;
    logic            busy_q;
    logic            err_q;
    logic [15:0]     tri_count_q;

    logic            wr_start;
    logic [AW-1:0]   wr_addr;
    logic [31:0]     wr_data;
    logic            wr_idle;
    logic            wr_req_done;
    logic            wr_resp_done;
    logic            wr_resp_err;
    logic            rd_take;
    logic            status_full;
    logic            unused_rdata;

    assign rd_take      = rready_q & m00_axi.m00_axi_rvalid;
    assign status_full  = m00_axi.m00_axi_rdata[STATUS_FULL_BIT];
    assign unused_rdata = ^m00_axi.m00_axi_rdata;

    // Writes are launched on the same edge the FSM enters the write state, keeping a zero-wait word at 2 cycles.
    always_comb begin
        wr_start = 1'b0;
        wr_addr  = FIFO_ADDR;
        wr_data  = word_q[0];
        case (state_q)
            ST_WAKE_AW: begin
                if (wr_idle) begin
                    wr_start = 1'b1;
                    wr_addr  = STATUS_ADDR;
                    wr_data  = WAKE_CMD;
                end
            end
            ST_POLL_R: wr_start = rd_take & ~status_full;
            ST_WR_B: begin
                if (wr_resp_done && idx_q != 2'd3) begin
                    wr_start = 1'b1;
                    wr_data  = word_q[idx_q + 2'd1];
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge m00_axi_aclk) begin
        if (m00_axi_areset) begin
            state_q     <= ST_WAKE_AW;
            word_q      <= '0;
            idx_q       <= 2'd0;
            araddr_q    <= '0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            tri_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            err_q       <= 1'b0;
            tri_count_q <= 16'd0;
        end else begin
            if ((rd_take && m00_axi.m00_axi_rresp != AXI_RESP_OKAY) || wr_resp_err) err_q <= 1'b1;
            case (state_q)
                ST_WAKE_AW: if (wr_req_done) state_q <= ST_WAKE_B;
                ST_WAKE_B: begin
                    if (wr_resp_done) begin
                        state_q     <= ST_IDLE;
                        tri_ready_q <= 1'b1;
                        busy_q      <= 1'b0;
                    end
                end
                ST_IDLE: begin
                    if (tri_valid && tri_ready_q) begin
                        word_q      <= pack_triangle(tri_x1, tri_y1, tri_x2, tri_y2,
                                                     tri_x3, tri_c1, tri_c2, tri_c3);
                        tri_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        araddr_q    <= STATUS_ADDR;
                        arvalid_q   <= 1'b1;
                        state_q     <= ST_POLL_AR;
                    end
                end
                ST_POLL_AR: begin
                    if (m00_axi.m00_axi_arready) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= ST_POLL_R;
                    end
                end
                ST_POLL_R: begin
                    if (m00_axi.m00_axi_rvalid) begin
                        rready_q <= 1'b0;
                        if (status_full) begin
                            arvalid_q <= 1'b1;
                            state_q   <= ST_POLL_AR;
                        end else begin
                            idx_q   <= 2'd0;
                            state_q <= ST_WR_AW;
                        end
                    end
                end
                ST_WR_AW: if (wr_req_done) state_q <= ST_WR_B;
                ST_WR_B: begin
                    if (wr_resp_done) begin
                        if (idx_q == 2'd3) begin
                            tri_count_q <= tri_count_q + 16'd1;
                            tri_ready_q <= 1'b1;
                            busy_q      <= 1'b0;
                            state_q     <= ST_IDLE;
                        end else begin
                            idx_q   <= idx_q + 2'd1;
                            state_q <= ST_WR_AW;
                        end
                    end
                end
                default: state_q <= ST_WAKE_AW;
            endcase
        end
    end

    axil_single_write #(.AW(AW)) u_write (
        .clk         (m00_axi_aclk),
        .rst         (m00_axi_areset),
        .start_i     (wr_start),
        .addr_i      (wr_addr),
        .data_i      (wr_data),
        .awaddr_o    (m00_axi.m00_axi_awaddr),
        .awvalid_o   (m00_axi.m00_axi_awvalid),
        .awready_i   (m00_axi.m00_axi_awready),
        .wdata_o     (m00_axi.m00_axi_wdata),
        .wvalid_o    (m00_axi.m00_axi_wvalid),
        .wready_i    (m00_axi.m00_axi_wready),
        .bresp_i     (m00_axi.m00_axi_bresp),
        .bvalid_i    (m00_axi.m00_axi_bvalid),
        .bready_o    (m00_axi.m00_axi_bready),
        .idle_o      (wr_idle),
        .req_done_o  (wr_req_done),
        .resp_done_o (wr_resp_done),
        .resp_err_o  (wr_resp_err)
    );

    assign m00_axi.m00_axi_awprot  = AXI_PROT_DEFAULT;
    assign m00_axi.m00_axi_wstrb   = AXI_STRB_FULL;
    assign m00_axi.m00_axi_araddr  = araddr_q;
    assign m00_axi.m00_axi_arprot  = AXI_PROT_DEFAULT;
    assign m00_axi.m00_axi_arvalid = arvalid_q;
    assign m00_axi.m00_axi_rready  = rready_q;

    assign tri_ready = tri_ready_q;
    assign busy      = busy_q;
    assign err       = err_q;
    assign tri_count = tri_count_q;

endmodule

// File: tb/tb_draw_fifo_axi_master.sv
// tb/tb_draw_fifo_axi_master.sv - vector-table bench for draw_fifo_axi_master with a reactive AXI4-Lite slave
module tb_draw_fifo_axi_master;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        tri_valid = 1'b0;
    logic        tri_ready;
    logic [15:0] x1 = '0, y1 = '0, x2 = '0, y2 = '0, x3 = '0, c1 = '0, c2 = '0, c3 = '0;
    logic        busy, err;
    logic [15:0] tri_count;

    always #5 clk = ~clk;

    draw_fifo_axi_master_if #(.ADDR_W(32)) bus ();

    draw_fifo_axi_master #(.C_M00_AXI_ADDR_WIDTH(32), .C_BASE_ADDR(32'h0)) dut (
        .m00_axi_aclk(clk), .m00_axi_areset(rst),
        .tri_valid(tri_valid), .tri_ready(tri_ready),
        .tri_x1(x1), .tri_y1(y1), .tri_x2(x2), .tri_y2(y2),
        .tri_x3(x3), .tri_c1(c1), .tri_c2(c2), .tri_c3(c3),
        .busy(busy), .err(err), .tri_count(tri_count),
        .m00_axi(bus.master)
    );

    // Slave knobs, written only by the stimulus process.
    int full_polls = 0;
    int bad_wr_abs = -1;
    bit aw_hold    = 1'b0;
    int ar_base    = 0;

    // Slave state and logs, written only by the slave/monitor processes.
    logic        s_rvalid = 1'b0, s_bvalid = 1'b0, aw_got = 1'b0, w_got = 1'b0;
    logic [31:0] s_rdata = '0, aw_a = '0, w_d = '0;
    logic [1:0]  s_bresp = '0;
    int          wcnt = 0, ar_cnt = 0, b_cnt = 0, hold_cycles = 0, addr_moves = 0, overlap = 0;
    logic [31:0] wa_log[$], wd_log[$];
    int          ar_at_wr[$];
    logic        aw_fire, w_fire;

    assign bus.m00_axi_arready = 1'b1;
    assign bus.m00_axi_wready  = 1'b1;
    assign bus.m00_axi_awready = !aw_hold || (wcnt >= 3);
    assign bus.m00_axi_rvalid  = s_rvalid;
    assign bus.m00_axi_rdata   = s_rdata;
    assign bus.m00_axi_rresp   = 2'b00;
    assign bus.m00_axi_bvalid  = s_bvalid;
    assign bus.m00_axi_bresp   = s_bresp;
    assign aw_fire = bus.m00_axi_awvalid & bus.m00_axi_awready;
    assign w_fire  = bus.m00_axi_wvalid & bus.m00_axi_wready;

    always @(posedge clk) begin
        if (rst) begin
            s_rvalid <= 1'b0; s_bvalid <= 1'b0; aw_got <= 1'b0; w_got <= 1'b0; wcnt <= 0;
        end else begin
            if (bus.m00_axi_arvalid && bus.m00_axi_arready) begin
                s_rvalid <= 1'b1;
                s_rdata  <= ((ar_cnt - ar_base) < full_polls) ? 32'h1 : 32'h0;
                ar_cnt   <= ar_cnt + 1;
            end else if (s_rvalid && bus.m00_axi_rready) begin
                s_rvalid <= 1'b0;
            end
            if ((aw_got || aw_fire) && (w_got || w_fire)) begin
                wa_log.push_back(aw_fire ? bus.m00_axi_awaddr : aw_a);
                wd_log.push_back(w_fire ? bus.m00_axi_wdata : w_d);
                ar_at_wr.push_back(ar_cnt);
                s_bresp  <= (wd_log.size() == bad_wr_abs) ? 2'b10 : 2'b00;
                s_bvalid <= 1'b1;
                aw_got <= 1'b0; w_got <= 1'b0; wcnt <= 0;
            end else begin
                if (aw_fire) begin aw_got <= 1'b1; aw_a <= bus.m00_axi_awaddr; end
                if (w_fire)  begin w_got  <= 1'b1; w_d  <= bus.m00_axi_wdata;  end
                if (w_got && !aw_got) wcnt <= wcnt + 1;
            end
            if (s_bvalid && bus.m00_axi_bready) begin
                s_bvalid <= 1'b0;
                b_cnt    <= b_cnt + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (bus.m00_axi_arvalid && (bus.m00_axi_awvalid || bus.m00_axi_wvalid)) overlap <= overlap + 1;
        if (bus.m00_axi_awvalid && !bus.m00_axi_wvalid) begin
            hold_cycles <= hold_cycles + 1;
            if (bus.m00_axi_awaddr != 32'h0) addr_moves <= addr_moves + 1;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [15:0]      x1, y1, x2, y2, x3, c1, c2, c3;
        int               full_polls;
        int               bad_idx;
        bit               hold;
        logic [3:0][31:0] w;
        int               exp_ar;
        int               exp_lat;
        int               exp_hold;
        logic             exp_err;
        logic [15:0]      exp_cnt;
    } vec_t;

    vec_t vecs[4];

    task automatic drive_tri(input vec_t v);
        x1 = v.x1; y1 = v.y1; x2 = v.x2; y2 = v.y2; x3 = v.x3; c1 = v.c1; c2 = v.c2; c3 = v.c3;
    endtask

    initial begin
        int lat, wbase, bbase, hbase, mbase, abase;

        // w packed as {W3, W2, W1, W0}
        vecs[0] = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8, 0, -1, 1'b0,
                    {32'h00080007, 32'h00060005, 32'h00040003, 32'h00020001}, 1, 11, 0, 1'b0, 16'd1};
        vecs[1] = '{16'h1234, 16'hABCD, 16'h0000, 16'hFFFF, 16'h5555, 16'hAAAA, 16'h0F0F, 16'hF0F0, 3, -1, 1'b0,
                    {32'hF0F00F0F, 32'hAAAA5555, 32'hFFFF0000, 32'hABCD1234}, 4, 17, 0, 1'b0, 16'd2};
        vecs[2] = '{16'h0011, 16'h0022, 16'h0033, 16'h0044, 16'h0055, 16'h0066, 16'h0077, 16'h0088, 0, 2, 1'b0,
                    {32'h00880077, 32'h00660055, 32'h00440033, 32'h00220011}, 1, 11, 0, 1'b1, 16'd3};
        vecs[3] = '{16'hDEAD, 16'hBEEF, 16'hCAFE, 16'hF00D, 16'h0001, 16'h8000, 16'h7FFF, 16'h1357, 0, -1, 1'b1,
                    {32'h13577FFF, 32'h80000001, 32'hF00DCAFE, 32'hBEEFDEAD}, 1, 27, 16, 1'b1, 16'd4};

        repeat (3) @(negedge clk);
        check("rst_awvalid", bus.m00_axi_awvalid, 0);
        check("rst_wvalid", bus.m00_axi_wvalid, 0);
        check("rst_arvalid", bus.m00_axi_arvalid, 0);
        check("rst_bready", bus.m00_axi_bready, 0);
        check("rst_rready", bus.m00_axi_rready, 0);
        check("rst_awaddr", bus.m00_axi_awaddr, 0);
        check("rst_wdata", bus.m00_axi_wdata, 0);
        check("rst_tri_ready", tri_ready, 0);
        check("rst_busy", busy, 1);
        check("rst_err", err, 0);
        check("rst_tri_count", tri_count, 0);

        rst = 1'b0;
        @(negedge clk);
        check("wake_awvalid", bus.m00_axi_awvalid, 1);
        check("wake_wvalid", bus.m00_axi_wvalid, 1);
        check("wake_awaddr", bus.m00_axi_awaddr, 32'h4);
        check("wake_wdata", bus.m00_axi_wdata, 32'h80000000);
        check("wake_wstrb", bus.m00_axi_wstrb, 4'hF);
        check("wake_awprot", bus.m00_axi_awprot, 3'b000);
        lat = 0;
        while (!tri_ready && lat < 100) begin @(negedge clk); lat++; end
        check("wake_ready_reached", tri_ready, 1);
        check("wake_busy", busy, 0);
        check("wake_log_size", wd_log.size(), 1);
        check("wake_log_addr", (wa_log.size() > 0) ? wa_log[0] : 32'hxxxxxxxx, 32'h4);
        check("wake_log_data", (wd_log.size() > 0) ? wd_log[0] : 32'hxxxxxxxx, 32'h80000000);

        for (int v = 0; v < 4; v++) begin
            full_polls = vecs[v].full_polls;
            ar_base    = ar_cnt;
            wbase = wd_log.size(); bbase = b_cnt; hbase = hold_cycles; mbase = addr_moves;
            bad_wr_abs = (vecs[v].bad_idx < 0) ? -1 : wbase + vecs[v].bad_idx;
            aw_hold    = vecs[v].hold;
            drive_tri(vecs[v]);
            tri_valid = 1'b1;
            @(negedge clk);
            tri_valid = 1'b0;
            check("accept_arvalid", bus.m00_axi_arvalid, 1);
            check("accept_araddr", bus.m00_axi_araddr, 32'h4);
            check("accept_tri_ready", tri_ready, 0);
            check("accept_arprot", bus.m00_axi_arprot, 3'b000);
            lat = 1;
            while (!tri_ready && lat < 300) begin @(negedge clk); lat++; end
            check("latency", lat, vecs[v].exp_lat);
            check("write_count", wd_log.size() - wbase, 4);
            for (int i = 0; i < 4; i++) begin
                check("write_addr", (wbase + i < wa_log.size()) ? wa_log[wbase + i] : 32'hxxxxxxxx, 32'h0);
                check("write_data", (wbase + i < wd_log.size()) ? wd_log[wbase + i] : 32'hxxxxxxxx, vecs[v].w[i]);
            end
            check("ar_count", ar_cnt - ar_base, vecs[v].exp_ar);
            check("ar_before_first_aw", (wbase < ar_at_wr.size()) ? ar_at_wr[wbase] - ar_base : -1, vecs[v].exp_ar);
            check("b_count", b_cnt - bbase, 4);
            check("aw_hold_cycles", hold_cycles - hbase, vecs[v].exp_hold);
            check("awaddr_stable", addr_moves - mbase, 0);
            check("tri_count", tri_count, vecs[v].exp_cnt);
            check("err", err, vecs[v].exp_err);
            check("busy_done", busy, 0);
        end

        // Reset while the second word's B response is pending.
        aw_hold = 1'b0; full_polls = 0; bad_wr_abs = -1;
        ar_base = ar_cnt;
        wbase = wd_log.size();
        drive_tri(vecs[0]);
        tri_valid = 1'b1;
        @(negedge clk);
        tri_valid = 1'b0;
        lat = 0;
        while (!(bus.m00_axi_bready && (wd_log.size() - wbase == 2)) && lat < 100) begin @(negedge clk); lat++; end
        check("reached_wr_b_w1", bus.m00_axi_bready, 1);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_awvalid", bus.m00_axi_awvalid, 0);
        check("mid_rst_wvalid", bus.m00_axi_wvalid, 0);
        check("mid_rst_arvalid", bus.m00_axi_arvalid, 0);
        check("mid_rst_bready", bus.m00_axi_bready, 0);
        check("mid_rst_rready", bus.m00_axi_rready, 0);
        check("mid_rst_tri_count", tri_count, 0);
        check("mid_rst_err", err, 0);
        check("mid_rst_busy", busy, 1);
        rst = 1'b0;
        wbase = wd_log.size();
        abase = ar_cnt;
        lat = 0;
        while (!tri_ready && lat < 100) begin @(negedge clk); lat++; end
        check("rewake_ready", tri_ready, 1);
        check("rewake_count", wd_log.size() - wbase, 1);
        check("rewake_addr", (wbase < wa_log.size()) ? wa_log[wbase] : 32'hxxxxxxxx, 32'h4);
        check("rewake_data", (wbase < wd_log.size()) ? wd_log[wbase] : 32'hxxxxxxxx, 32'h80000000);
        repeat (20) @(negedge clk);
        check("no_resume_writes", wd_log.size() - wbase, 1);
        check("no_resume_reads", ar_cnt - abase, 0);
        check("no_resume_count", tri_count, 0);
        check("no_resume_busy", busy, 0);
        check("ar_aw_overlap", overlap, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
        $fatal(1);
    end

endmodule
